output_port_allocator: RTL
==========================

Name: output_port_allocator

Overview:
Per-output-port switch allocator for the NoC router. One instance sits on each of the NUM_INPUTS router outputs, local port 0 included. It arbitrates round-robin among input ports requesting this output and masks turns disabled by the DISABLE_TURNS column for this output. Once a head flit wins, the output is locked to that input until its tail flit passes. It also tracks downstream buffer credits, so a flit is granted only when the downstream FLIT_BUFFER_DEPTH buffer has space.

Parameters:
NUM_INPUTS, 5, number of requesting input ports (local + N/S/E/W).
CREDIT_DEPTH, 1, downstream buffer depth in flits (= FLIT_BUFFER_DEPTH); legal 1..64.
CREDIT_WIDTH, $clog2(CREDIT_DEPTH+1), credit counter width (derived).
IDX_WIDTH, $clog2(NUM_INPUTS), input index width (derived).

Ports:
clk_noc  in  1  NoC clock.
rst_noc_sync  in  1  synchronous active-high reset.
req  in  NUM_INPUTS  bit i: input i holds a valid flit routed to this output.
req_is_tail  in  NUM_INPUTS  bit i: the flit at input i is a tail (single-flit packets have head=tail).
turn_disable  in  NUM_INPUTS  bit i: turn from input i to this output is forbidden.
credit_in  in  1  one-cycle pulse; downstream freed one flit slot.
grant  out  NUM_INPUTS  one-hot/zero, combinational; input i's flit transfers this cycle.
send_out  out  1  registered; a flit was granted the previous cycle.
is_tail_out  out  1  registered; the flit granted the previous cycle was a tail.
locked  out  1  output is mid-packet.
lock_owner  out  IDX_WIDTH  owning input while locked; 0 when not locked.
credits  out  CREDIT_WIDTH  current credit count.
err_credit_overflow  out  1  sticky; credit returned while the counter was full.

Behaviour:
- Clocking and reset:
  - Single clock clk_noc; synchronous active-high reset rst_noc_sync; all state updates on the rising edge.
  - Reset values: state IDLE, locked=0, lock_owner=0, rr_ptr=0, credits=CREDIT_DEPTH, send_out=0, is_tail_out=0, err_credit_overflow=0.
  - While rst_noc_sync=1, grant=0.
- Definitions:
  - fire = |grant.
  - eligible = req & ~turn_disable.
  - Grant requires credits>0. A credit_in in the same cycle does not enable a grant in that cycle (no bypass).
- Credit counter:
  - credits_next = credits - fire + credit_in; a simultaneous fire and credit_in leaves credits unchanged.
  - If credit_in=1 and fire=0 while credits==CREDIT_DEPTH: credits saturates at CREDIT_DEPTH and err_credit_overflow sets. It clears only on reset.
- IDLE state:
  - If credits>0 and eligible!=0: grant the first eligible input searching cyclically from rr_ptr upward (wrap NUM_INPUTS-1 -> 0).
  - On a grant, rr_ptr <= (winner+1) mod NUM_INPUTS. rr_ptr does not change without a grant.
  - If the winner's req_is_tail=1: remain IDLE (single-flit packet).
  - Otherwise: go to LOCKED with lock_owner <= winner, locked <= 1.
- LOCKED state:
  - Only lock_owner may be granted, when req[lock_owner]=1 and credits>0. turn_disable is ignored mid-packet.
  - All other requests are held off regardless of priority.
  - A grant with req_is_tail[lock_owner]=1 returns to IDLE and clears locked/lock_owner on the next edge. rr_ptr is not updated in LOCKED.
  - If req[lock_owner] is absent (bubble): no grant, lock held indefinitely.
- Output registers:
  - send_out <= fire and is_tail_out <= (fire & req_is_tail of the granted input), each every cycle.
  - Latency: grant -> send_out is 1 cycle.
- grant is purely combinational from the registered state and current inputs; it does not depend on credit_in.
- Reset mid-packet: abandons the lock immediately; the next cycle is IDLE with full credits. Upstream/downstream flushing is the wrapper's responsibility.
- Boundary conditions:
  - With credits==0, req is held off with no grant and no state change.
  - NUM_INPUTS that is not a power of two: rr_ptr wraps at NUM_INPUTS, never at 2^IDX_WIDTH.

Test Plan:
- Reset, CREDIT_DEPTH=4 -> credits=4, grant=0, send_out=0, locked=0.
- req=5'b10110, all tails, credits=4 -> grants in order 1,2,4, then 1 again; rr_ptr after each grant = 2,3,0,2.
- Input 3 sends head (req_is_tail=0) while input 1 also requests -> grant=3, locked=1, lock_owner=3. Input 1 is not granted until input 3's tail grant. The next IDLE cycle grants 1.
- CREDIT_DEPTH=1: grant flit -> credits=0. Req held with no grant for 3 cycles. credit_in pulse -> grant on the following cycle, not the same cycle.
- turn_disable=5'b00100, req=5'b00100 in IDLE -> no grant. Same mask applied while input 2 already owns the lock -> grant continues.
- credit_in with credits=CREDIT_DEPTH and no fire -> credits stays 4, err_credit_overflow=1 until reset. Reset asserted mid-packet -> locked=0, credits=4 next cycle.

Source files
------------

// File: rtl/output_port_allocator.sv
// -----------------------------------------------------------------------------
// output_port_allocator
//
// Switch allocator for one router output. Arbitrates round-robin among the
// input ports requesting this output (minus forbidden turns), holds the
// output for the winning input until its tail flit has passed, and tracks
// credits for the downstream flit buffer so a flit is granted only when
// that buffer has room.
//
// Ports:
//   clk_noc             in   NoC clock
//   rst_noc_sync        in   synchronous active-high reset
//   req                 in   per-input: valid flit routed to this output
//   req_is_tail         in   per-input: that flit is a tail (head=tail allowed)
//   turn_disable        in   per-input: turn into this output is forbidden
//   credit_in           in   pulse: downstream freed one slot
//   grant               out  one-hot/zero, combinational transfer enable
//   send_out            out  registered: a flit was granted last cycle
//   is_tail_out         out  registered: last cycle's granted flit was a tail
//   locked              out  output is mid-packet
//   lock_owner          out  owning input while locked, 0 otherwise
//   credits             out  current credit count
//   err_credit_overflow out  sticky: credit returned while counter was full
// -----------------------------------------------------------------------------
module output_port_allocator #(
    parameter int NUM_INPUTS   = 5,
    parameter int CREDIT_DEPTH = 1,
    parameter int CREDIT_WIDTH = $clog2(CREDIT_DEPTH + 1),
    parameter int IDX_WIDTH    = $clog2(NUM_INPUTS)
) (
    input  logic                    clk_noc,
    input  logic                    rst_noc_sync,
    input  logic [NUM_INPUTS-1:0]   req,
    input  logic [NUM_INPUTS-1:0]   req_is_tail,
    input  logic [NUM_INPUTS-1:0]   turn_disable,
    input  logic                    credit_in,
    output logic [NUM_INPUTS-1:0]   grant,
    output logic                    send_out,
    output logic                    is_tail_out,
    output logic                    locked,
    output logic [IDX_WIDTH-1:0]    lock_owner,
    output logic [CREDIT_WIDTH-1:0] credits,
    output logic                    err_credit_overflow
);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    localparam logic [CREDIT_WIDTH-1:0] CREDIT_FULL = CREDIT_WIDTH'(CREDIT_DEPTH);
    localparam logic [IDX_WIDTH-1:0]    LAST_IDX    = IDX_WIDTH'(NUM_INPUTS - 1);

    // Returns {found, index} of the first set bit of elig scanning upward
    // from ptr and wrapping at NUM_INPUTS (not at 2**IDX_WIDTH). The scan
    // runs from the farthest offset down so the nearest hit is written last.
    function automatic logic [IDX_WIDTH:0] rr_pick(
        input logic [NUM_INPUTS-1:0] elig,
        input logic [IDX_WIDTH-1:0]  ptr
    );
        logic [IDX_WIDTH:0]   res;
        logic [IDX_WIDTH-1:0] ci;
        int                   cand;
        res = '0;
        for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
            cand = int'(ptr) + k;
            if (cand >= NUM_INPUTS) begin
                cand = cand - NUM_INPUTS;
            end else begin
                cand = cand;
            end
            ci = IDX_WIDTH'(cand);
            if (elig[ci]) begin
                res = {1'b1, ci};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    state_t                  state_q, state_d;
    logic [IDX_WIDTH-1:0]    lock_owner_q, lock_owner_d;
    logic [IDX_WIDTH-1:0]    rr_ptr_q, rr_ptr_d;
    logic [CREDIT_WIDTH-1:0] credits_q, credits_d;
    logic                    send_q, send_d;
    logic                    tail_q, tail_d;
    logic                    err_q, err_d;

    logic [NUM_INPUTS-1:0]   eligible_s;
    logic [IDX_WIDTH:0]      pick_s;
    logic                    found_s;
    logic [IDX_WIDTH-1:0]    winner_s;
    logic [NUM_INPUTS-1:0]   grant_s;
    logic                    fire_s;
    logic                    win_tail_s;

    assign eligible_s = req & ~turn_disable;
    assign pick_s     = rr_pick(eligible_s, rr_ptr_q);

    // Grant selection: round-robin in IDLE, owner-only in LOCKED, gated by
    // registered credits so a same-cycle credit_in cannot enable a grant.
    always_comb begin
        found_s  = 1'b0;
        winner_s = '0;
        if (rst_noc_sync) begin
            found_s  = 1'b0;
            winner_s = '0;
        end else if (credits_q == '0) begin
            found_s  = 1'b0;
            winner_s = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    found_s  = pick_s[IDX_WIDTH];
                    winner_s = pick_s[IDX_WIDTH-1:0];
                end
                ST_LOCKED: begin
                    // turn_disable is deliberately ignored mid-packet
                    found_s  = req[lock_owner_q];
                    winner_s = lock_owner_q;
                end
                default: begin
                    found_s  = 1'b0;
                    winner_s = '0;
                end
            endcase
        end
        if (found_s) begin
            grant_s = NUM_INPUTS'(1'b1) << winner_s;
        end else begin
            grant_s = '0;
        end
    end

    assign fire_s     = |grant_s;
    assign win_tail_s = fire_s & req_is_tail[winner_s];

    // Next-state logic: lock FSM, round-robin pointer, credits, output flops.
    always_comb begin
        state_d      = state_q;
        lock_owner_d = lock_owner_q;
        rr_ptr_d     = rr_ptr_q;
        credits_d    = credits_q;
        err_d        = err_q;
        send_d       = fire_s;
        tail_d       = win_tail_s;

        case (state_q)
            ST_IDLE: begin
                if (fire_s) begin
                    rr_ptr_d = (winner_s == LAST_IDX) ? '0 : winner_s + IDX_WIDTH'(1);
                    if (win_tail_s) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d      = ST_LOCKED;
                        lock_owner_d = winner_s;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOCKED: begin
                if (win_tail_s) begin
                    state_d      = ST_IDLE;
                    lock_owner_d = '0;
                end else begin
                    state_d = ST_LOCKED;
                end
            end
            default: begin
                state_d      = ST_IDLE;
                lock_owner_d = '0;
            end
        endcase

        // Simultaneous fire and credit return cancel out.
        if (fire_s && !credit_in) begin
            credits_d = credits_q - CREDIT_WIDTH'(1);
        end else if (!fire_s && credit_in) begin
            if (credits_q == CREDIT_FULL) begin
                credits_d = CREDIT_FULL;
                err_d     = 1'b1;
            end else begin
                credits_d = credits_q + CREDIT_WIDTH'(1);
            end
        end else begin
            credits_d = credits_q;
        end
    end

    // State registers with synchronous reset; reset drops any lock at once.
    always_ff @(posedge clk_noc) begin
        if (rst_noc_sync) begin
            state_q      <= ST_IDLE;
            lock_owner_q <= '0;
            rr_ptr_q     <= '0;
            credits_q    <= CREDIT_FULL;
            send_q       <= 1'b0;
            tail_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            lock_owner_q <= lock_owner_d;
            rr_ptr_q     <= rr_ptr_d;
            credits_q    <= credits_d;
            send_q       <= send_d;
            tail_q       <= tail_d;
            err_q        <= err_d;
        end
    end

    assign grant               = grant_s;
    assign send_out            = send_q;
    assign is_tail_out         = tail_q;
    assign locked              = (state_q == ST_LOCKED);
    assign lock_owner          = lock_owner_q;
    assign credits             = credits_q;
    assign err_credit_overflow = err_q;

endmodule
